// File: rtl/rom_step_ctrl.sv
// Single-clock sequencer for the 7-segment pattern ROM: steps the address on a
// synchronized 4-phase request or an auto-step tick, then latches the word for display.
module rom_step_ctrl #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 16,
    parameter int AUTO_DIV = 50_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_R,
    output logic              in_A,
    input  logic              auto_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] disp_data,
    output logic              busy,
    output logic [2:0]        dbg_state
);

    localparam int CNT_W = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(AUTO_DIV - 1);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_ACK   = 3'd3,
        S_IDLE  = 3'd4
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] disp_q;
    logic              ack_q;
    logic              manual_q;
    logic              req_meta_q, req_s;
    logic              auto_meta_q, auto_s;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tick;

    // Both inputs are asynchronous to clk; only the second flop of each pair is used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_meta_q  <= 1'b0;
            req_s       <= 1'b0;
            auto_meta_q <= 1'b0;
            auto_s      <= 1'b0;
        end else begin
            req_meta_q  <= in_R;
            req_s       <= req_meta_q;
            auto_meta_q <= auto_en;
            auto_s      <= auto_meta_q;
        end
    end

    assign tick = auto_s && (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!auto_s || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // 4-phase handshake: source raises in_R, we raise in_A once disp_data holds the new
    // word, source drops in_R, we drop in_A; only then is the next request accepted.
    // A manual request outranks a same-cycle tick; ticks outside IDLE are simply lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_INIT;
            addr_q   <= '0;
            disp_q   <= '0;
            ack_q    <= 1'b0;
            manual_q <= 1'b0;
        end else begin
            case (state_q)
                S_INIT: begin
                    state_q <= S_FETCH;
                end
                S_IDLE: begin
                    if (req_s && !ack_q) begin
                        addr_q   <= addr_q + ADDR_W'(1);
                        manual_q <= 1'b1;
                        state_q  <= S_FETCH;
                    end else if (tick) begin
                        addr_q   <= addr_q + ADDR_W'(1);
                        manual_q <= 1'b0;
                        state_q  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state_q <= S_LATCH;
                end
                S_LATCH: begin
                    disp_q <= rom_data;
                    if (manual_q) begin
                        ack_q   <= 1'b1;
                        state_q <= S_ACK;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ACK: begin
                    if (!req_s) begin
                        ack_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_INIT;
                end
            endcase
        end
    end

    assign in_A      = ack_q;
    assign rom_addr  = addr_q;
    assign disp_data = disp_q;
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule
